assembler_scan_sequencer: RTL and testbench

Sequences the two-pass assembly scan (PC mapping, then instruction mapping) over the text editor buffer. Arbitrates the text buffer's single port between terminal writes and assembler reads. Feeds the assembler one character at a time, with line and character coordinates. Sits between terminal_controller, text_editor and assembler, and replaces the ad-hoc scan logic in top_level.

---
 rtl/assembler_scan_sequencer_pkg.sv | 21 ++
 rtl/assembler_scan_sequencer_text_port_arbiter.sv | 22 ++
 rtl/assembler_scan_sequencer.sv | 173 +++++++++++++++++
 tb/tb_assembler_scan_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assembler_scan_sequencer_pkg.sv
// Shared types for the assembler scan sequencer.
// Pass-level state and per-line scan FSM encodings.
package assembler_scan_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PC_MAPPING,
    INSTRUCTION_MAPPING,
    SUCCESS,
    ERROR
  } assembler_state_t;

  typedef enum logic [2:0] {
    NEW_LINE,
    ISSUE,
    WAIT,
    PRESENT,
    PASS_END
  } line_fsm_t;

endpackage

// File: rtl/assembler_scan_sequencer_text_port_arbiter.sv
// Single-port text buffer mux: terminal writes always win,
// scan reads are granted only in write-free cycles.
module text_port_arbiter #(
  parameter int AW = 14
) (
  input  logic          tg_we,
  input  logic [AW-1:0] tg_addr,
  input  logic [7:0]    tg_data,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data
);

  assign mem_we   = tg_we;
  assign mem_addr = tg_we ? tg_addr : rd_addr;
  assign mem_data = tg_we ? tg_data : 8'h00;
  assign rd_gnt   = rd_req & ~tg_we;

endmodule

// File: rtl/assembler_scan_sequencer.sv
// Two-pass assembler scan over the text buffer, one character
// at a time, sharing the buffer port with terminal writes.
module assembler_scan_sequencer
  import assembler_scan_sequencer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 64,
  parameter int SCREEN_HEIGHT = 256,
  parameter int READ_LATENCY  = 2,
  localparam int AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  localparam int CW = $clog2(SCREEN_WIDTH),
  localparam int LW = $clog2(SCREEN_HEIGHT)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             tg_we_in,
  input  logic [AW-1:0]    tg_addr_in,
  input  logic [7:0]       tg_data_in,
  output logic             mem_we_out,
  output logic [AW-1:0]    mem_addr_out,
  output logic [7:0]       mem_data_out,
  input  logic [7:0]       mem_rdata_in,
  output logic             asm_new_line_out,
  output logic             asm_new_char_out,
  output logic [LW-1:0]    asm_line_out,
  output logic [CW-1:0]    asm_char_out,
  output logic [7:0]       asm_char_data_out,
  input  logic             asm_done_in,
  input  logic             asm_error_in,
  output assembler_state_t asm_state_out,
  output logic             busy_out
);

  localparam logic [CW-1:0] COL_LAST  = CW'(SCREEN_WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(SCREEN_HEIGHT - 1);

  assembler_state_t        as_q, as_d;
  line_fsm_t               ls_q, ls_d;
  logic [LW-1:0]           line_q, line_d;
  logic [CW-1:0]           col_q, col_d;
  logic                    dp_q, dp_d;
  logic [READ_LATENCY-1:0] lat_q, lat_d;
  logic [7:0]              data_q, data_d;
  logic busy, rd_req, rd_gnt, eol, done_now;
  logic new_line, new_char;

  text_port_arbiter #(.AW(AW)) u_arb (
    .tg_we    (tg_we_in),
    .tg_addr  (tg_addr_in),
    .tg_data  (tg_data_in),
    .rd_req   (rd_req),
    .rd_addr  ({line_q, col_q}),
    .rd_gnt   (rd_gnt),
    .mem_we   (mem_we_out),
    .mem_addr (mem_addr_out),
    .mem_data (mem_data_out)
  );

  assign busy = (as_q == PC_MAPPING) ||
                (as_q == INSTRUCTION_MAPPING);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      as_q   <= IDLE;
      ls_q   <= NEW_LINE;
      line_q <= '0;
      col_q  <= '0;
      dp_q   <= 1'b0;
      lat_q  <= '0;
      data_q <= '0;
    end else begin
      as_q   <= as_d;
      ls_q   <= ls_d;
      line_q <= line_d;
      col_q  <= col_d;
      dp_q   <= dp_d;
      lat_q  <= lat_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    as_d     = as_q;
    ls_d     = ls_q;
    line_d   = line_q;
    col_d    = col_q;
    dp_d     = dp_q;
    lat_d    = lat_q << 1;
    data_d   = data_q;
    rd_req   = 1'b0;
    eol      = 1'b0;
    new_line = 1'b0;
    new_char = 1'b0;
    done_now = dp_q | asm_done_in;
    if (busy) begin
      if (asm_done_in) dp_d = 1'b1;
      unique case (ls_q)
        NEW_LINE: begin
          new_line = 1'b1;
          col_d    = '0;
          dp_d     = 1'b0;
          ls_d     = ISSUE;
        end
        ISSUE: begin
          if (done_now) eol = 1'b1;
          else begin
            rd_req = 1'b1;
            if (rd_gnt) ls_d = WAIT;
          end
        end
        WAIT: begin
          // Read always completes; a pending done drops its data.
          if (lat_q[READ_LATENCY-1]) begin
            if (done_now) eol = 1'b1;
            else begin
              data_d = mem_rdata_in;
              ls_d   = PRESENT;
            end
          end
        end
        PRESENT: begin
          new_char = 1'b1;
          if (done_now || col_q == COL_LAST) eol = 1'b1;
          else begin
            col_d = col_q + CW'(1);
            ls_d  = ISSUE;
          end
        end
        PASS_END: begin
          ls_d = NEW_LINE;
          if (as_q == PC_MAPPING) begin
            as_d   = INSTRUCTION_MAPPING;
            line_d = '0;
            col_d  = '0;
          end else begin
            as_d = SUCCESS;
          end
        end
        default: ls_d = NEW_LINE;
      endcase
      if (eol) begin
        if (line_q == LINE_LAST) ls_d = PASS_END;
        else begin
          line_d = line_q + LW'(1);
          ls_d   = NEW_LINE;
        end
      end
    end
    lat_d[0] = rd_req & rd_gnt;
    if (busy && asm_error_in) begin
      as_d  = ERROR;
      lat_d = '0;
    end
    // Restart wins over everything, including a same-cycle error.
    if (start_in) begin
      as_d   = PC_MAPPING;
      ls_d   = NEW_LINE;
      line_d = '0;
      col_d  = '0;
      dp_d   = 1'b0;
      lat_d  = '0;
    end
  end

  assign asm_new_line_out  = new_line;
  assign asm_new_char_out  = new_char;
  assign asm_line_out      = line_q;
  assign asm_char_out      = col_q;
  assign asm_char_data_out = data_q;
  assign asm_state_out     = as_q;
  assign busy_out          = busy;

endmodule

// File: tb/tb_assembler_scan_sequencer.sv
// Bench for assembler_scan_sequencer: W=4, H=2, latency 2,
// with a two-stage read memory model and a pulse scoreboard.
module tb_assembler_scan_sequencer;
  import assembler_scan_sequencer_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic start_in = 1'b0;
  logic tg_we_in = 1'b0;
  logic [2:0] tg_addr_in = '0;
  logic [7:0] tg_data_in = '0;
  logic mem_we_out;
  logic [2:0] mem_addr_out;
  logic [7:0] mem_data_out;
  logic [7:0] mem_rdata_in;
  logic asm_new_line_out, asm_new_char_out;
  logic [0:0] asm_line_out;
  logic [1:0] asm_char_out;
  logic [7:0] asm_char_data_out;
  logic asm_done_in = 1'b0;
  logic asm_error_in = 1'b0;
  assembler_state_t asm_state_out;
  logic busy_out;

  assembler_scan_sequencer #(
    .SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .READ_LATENCY(2)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .tg_we_in(tg_we_in), .tg_addr_in(tg_addr_in),
    .tg_data_in(tg_data_in), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_rdata_in(mem_rdata_in),
    .asm_new_line_out(asm_new_line_out),
    .asm_new_char_out(asm_new_char_out),
    .asm_line_out(asm_line_out), .asm_char_out(asm_char_out),
    .asm_char_data_out(asm_char_data_out),
    .asm_done_in(asm_done_in), .asm_error_in(asm_error_in),
    .asm_state_out(asm_state_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [7:0] mem [8];
  logic [7:0] p1, p2;
  always @(posedge clk_in) begin
    if (mem_we_out) mem[mem_addr_out] <= mem_data_out;
    p1 <= mem[mem_addr_out];
    p2 <= p1;
  end
  assign mem_rdata_in = p2;

  int nchk = 0;
  int nerr = 0;
  task automatic check(string name, int got, int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int nl; int line; int col; int data; int st; int cyc;
  } ev_t;
  ev_t sb[$];
  int ref_mem [8];

  task automatic push_ev(int nl, int st, int line, int col, int c);
    ev_t e;
    e.nl = nl; e.st = st; e.line = line; e.col = col; e.cyc = c;
    e.data = nl ? 0 : ref_mem[line*4 + col];
    sb.push_back(e);
  endtask

  // d: extra cycles inserted before line 0 col 1 (write stall)
  task automatic push_pass(int b, int st, int d, bit full);
    push_ev(1, st, 0, 0, b);
    for (int c = 0; c < 4; c++)
      push_ev(0, st, 0, c, b + 4 + 4*c + (c > 0 ? d : 0));
    push_ev(1, st, 1, 0, b + 17 + d);
    if (full)
      for (int c = 0; c < 4; c++)
        push_ev(0, st, 1, c, b + 21 + d + 4*c);
  endtask

  ev_t me;
  always @(negedge clk_in) begin
    if (rst_in && (asm_new_line_out || asm_new_char_out)) begin
      if (sb.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        me = sb.pop_front();
        check("pulse_kind",
              2*int'(asm_new_line_out) + int'(asm_new_char_out),
              me.nl ? 2 : 1);
        check("pulse_cycle", cyc, me.cyc);
        check("pulse_state", int'(asm_state_out), me.st);
        check("pulse_line", int'(asm_line_out), me.line);
        if (!me.nl) begin
          check("char_col", int'(asm_char_out), me.col);
          check("char_data", int'(asm_char_data_out), me.data);
        end
      end
    end
  end

  task automatic drive_at(int c);
    while (cyc < c) begin @(posedge clk_in); #1; end
  endtask

  task automatic at_cycle(int c);
    do @(negedge clk_in); while (cyc < c);
  endtask

  task automatic start_pulse(output int s);
    @(posedge clk_in); #1;
    start_in = 1'b1;
    s = cyc;
  endtask

  task automatic start_release();
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_state"}, int'(asm_state_out), int'(IDLE));
    check({tag, "_busy"}, int'(busy_out), 0);
    check({tag, "_pulses"},
          int'(asm_new_line_out) + int'(asm_new_char_out), 0);
    check({tag, "_line"}, int'(asm_line_out), 0);
    check({tag, "_col"}, int'(asm_char_out), 0);
    check({tag, "_cdata"}, int'(asm_char_data_out), 0);
    check({tag, "_we"}, int'(mem_we_out), 0);
    check({tag, "_addr"}, int'(mem_addr_out), 0);
    check({tag, "_wdata"}, int'(mem_data_out), 0);
  endtask

  typedef struct {
    logic we; logic [2:0] addr; logic [7:0] data;
    logic exp_we; logic [2:0] exp_addr; logic [7:0] exp_data;
  } vec_t;
  vec_t vt [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, b, b2;
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{1'b1, 3'(i), 8'(8'h41 + i),
                1'b1, 3'(i), 8'(8'h41 + i)};
    end
    // idle read address is line 0 col 0; write data muted
    vt[8] = '{1'b0, 3'd5, 8'hee, 1'b0, 3'd0, 8'h00};
    vt[9] = '{1'b1, 3'd3, 8'h5a, 1'b1, 3'd3, 8'h5a};

    repeat (2) @(negedge clk_in);
    check_zero_outputs("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // write path table, also fills the buffer
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      tg_we_in = vt[i].we;
      tg_addr_in = vt[i].addr;
      tg_data_in = vt[i].data;
      @(negedge clk_in);
      check("wr_we", int'(mem_we_out), int'(vt[i].exp_we));
      check("wr_addr", int'(mem_addr_out), int'(vt[i].exp_addr));
      check("wr_data", int'(mem_data_out), int'(vt[i].exp_data));
      if (vt[i].we) ref_mem[vt[i].addr] = int'(vt[i].data);
    end
    @(posedge clk_in); #1;
    tg_we_in = 1'b0;

    // clean two-pass scan
    start_pulse(s);
    b = s + 1;
    push_pass(b, int'(PC_MAPPING), 0, 1'b1);
    push_pass(b + 35, int'(INSTRUCTION_MAPPING), 0, 1'b1);
    start_release();
    at_cycle(b + 69);
    check("clean_pass2_state", int'(asm_state_out),
          int'(INSTRUCTION_MAPPING));
    at_cycle(b + 70);
    check("clean_success", int'(asm_state_out), int'(SUCCESS));
    check("clean_busy", int'(busy_out), 0);
    check("clean_sb_empty", sb.size(), 0);

    // terminal writes stall line 0 col 1 read for 3 cycles
    for (int k = 0; k < 3; k++) ref_mem[5 + k] = 8'h70 + k;
    start_pulse(s);
    b = s + 1;
    push_pass(b, int'(PC_MAPPING), 3, 1'b1);
    push_pass(b + 38, int'(INSTRUCTION_MAPPING), 0, 1'b1);
    start_release();
    for (int k = 0; k < 3; k++) begin
      drive_at(b + 5 + k);
      tg_we_in = 1'b1;
      tg_addr_in = 3'(5 + k);
      tg_data_in = 8'(8'h70 + k);
      at_cycle(b + 5 + k);
      check("cont_we", int'(mem_we_out), 1);
      check("cont_addr", int'(mem_addr_out), 5 + k);
      check("cont_data", int'(mem_data_out), 8'h70 + k);
    end
    drive_at(b + 8);
    tg_we_in = 1'b0;
    at_cycle(b + 8);
    check("cont_issue_we", int'(mem_we_out), 0);
    check("cont_issue_addr", int'(mem_addr_out), 1);
    at_cycle(b + 38 + 35);
    check("cont_success", int'(asm_state_out), int'(SUCCESS));
    check("cont_sb_empty", sb.size(), 0);

    // done during WAIT of line 0 col 1, then error in line 1
    start_pulse(s);
    b = s + 1;
    push_ev(1, int'(PC_MAPPING), 0, 0, b);
    push_ev(0, int'(PC_MAPPING), 0, 0, b + 4);
    push_ev(1, int'(PC_MAPPING), 1, 0, b + 8);
    push_ev(0, int'(PC_MAPPING), 1, 0, b + 12);
    start_release();
    drive_at(b + 6);
    asm_done_in = 1'b1;
    drive_at(b + 7);
    asm_done_in = 1'b0;
    drive_at(b + 14);
    asm_error_in = 1'b1;
    at_cycle(b + 14);
    check("err_pre_state", int'(asm_state_out), int'(PC_MAPPING));
    drive_at(b + 15);
    asm_error_in = 1'b0;
    at_cycle(b + 15);
    check("err_state", int'(asm_state_out), int'(ERROR));
    check("err_busy", int'(busy_out), 0);
    at_cycle(b + 40);
    check("err_hold", int'(asm_state_out), int'(ERROR));
    check("err_sb_empty", sb.size(), 0);

    // restart from ERROR, then restart mid-WAIT of pass 2 line 1
    start_pulse(s);
    b = s + 1;
    b2 = b + 35;
    push_pass(b, int'(PC_MAPPING), 0, 1'b1);
    push_pass(b2, int'(INSTRUCTION_MAPPING), 0, 1'b0);
    start_release();
    at_cycle(b);
    check("restart_state", int'(asm_state_out), int'(PC_MAPPING));
    drive_at(b2 + 19);
    start_in = 1'b1;
    push_ev(1, int'(PC_MAPPING), 0, 0, b2 + 20);
    drive_at(b2 + 20);
    start_in = 1'b0;
    at_cycle(b2 + 20);
    check("midpass_state", int'(asm_state_out), int'(PC_MAPPING));
    check("midpass_line", int'(asm_line_out), 0);

    // async reset while the col 0 read is in flight
    drive_at(b2 + 22);
    check("pre_reset_busy", int'(busy_out), 1);
    #2;
    rst_in = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
